// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: raster pixel stream in, 3x3 window with centre coordinates out
interface window_gen_3x3_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0]   data_i;
    logic                data_en_i;
    logic                clear_i;
    logic [9*DATA_W-1:0] win_o;
    logic                win_en_o;
    logic [9:0]          win_row_o;
    logic [9:0]          win_col_o;
    logic                frame_done_o;
    modport master (
        output data_i, data_en_i, clear_i,
        input  win_o, win_en_o, win_row_o, win_col_o, frame_done_o
    );
    modport slave (
        input  data_i, data_en_i, clear_i,
        output win_o, win_en_o, win_row_o, win_col_o, frame_done_o
    );
endinterface

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: two-line-buffered 3x3 neighbourhood generator for interior pixels
module window_gen_3x3 #(
    parameter int MAX_ROW = 360,
    parameter int MAX_COL = 540,
    parameter int DATA_W  = 8
) (
    input logic             clk,
    input logic             rst,
    window_gen_3x3_if.slave bus
);
    localparam int AW = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    logic [9:0]          col_q, col_d, row_q, row_d;
    logic [DATA_W-1:0]   lb0 [MAX_COL];
    logic [DATA_W-1:0]   lb1 [MAX_COL];
    logic [DATA_W-1:0]   win_q [9];
    logic [DATA_W-1:0]   win_d [9];
    logic [9*DATA_W-1:0] out_q, out_d;
    logic [9:0]          wrow_q, wrow_d, wcol_q, wcol_d;
    logic                en_q, en_d, done_q, done_d;
    logic                accept, last_col, last_row, emit;
    logic [AW-1:0]       addr;
    logic [DATA_W-1:0]   rd0, rd1;

    assign accept   = bus.data_en_i & ~bus.clear_i;
    assign last_col = col_q == 10'(MAX_COL - 1);
    assign last_row = row_q == 10'(MAX_ROW - 1);
    assign emit     = accept && row_q >= 10'd2 && col_q >= 10'd2;
    assign addr     = col_q[AW-1:0];
    assign rd0      = lb0[addr];
    assign rd1      = lb1[addr];

    // Raster position of the next pixel; clear and frame end both return to (0,0)
    always_comb begin
        col_d = bus.clear_i ? '0 : !accept ? col_q : last_col ? '0 : col_q + 10'd1;
        row_d = bus.clear_i ? '0 : !(accept && last_col) ? row_q : last_row ? '0 : row_q + 10'd1;
    end

    // Shift the window left and bring in the column {row r-2, row r-1, row r} at c
    always_comb begin
        for (int k = 0; k < 9; k++) win_d[k] = win_q[k];
        if (accept) begin
            for (int y = 0; y < 3; y++) begin
                win_d[3*y]   = win_q[3*y+1];
                win_d[3*y+1] = win_q[3*y+2];
            end
            win_d[2] = rd1;
            win_d[5] = rd0;
            win_d[8] = bus.data_i;
        end
    end

    // Capture a window and its centre only for interior pixels; otherwise hold
    always_comb begin
        out_d = out_q;
        if (emit) for (int k = 0; k < 9; k++) out_d[k*DATA_W +: DATA_W] = win_d[k];
        wrow_d = emit ? row_q - 10'd1 : wrow_q;
        wcol_d = emit ? col_q - 10'd1 : wcol_q;
        en_d   = emit;
        done_d = emit && last_row && last_col;
    end

    // Line buffers: read-before-write so lb1 receives the row lb0 held
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[addr] <= rd0;
            lb0[addr] <= bus.data_i;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
            out_q  <= '0;
            wrow_q <= '0;
            wcol_q <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
            out_q  <= out_d;
            wrow_q <= wrow_d;
            wcol_q <= wcol_d;
            en_q   <= en_d;
            done_q <= done_d;
        end
    end

    assign bus.win_o        = out_q;
    assign bus.win_en_o     = en_q;
    assign bus.win_row_o    = wrow_q;
    assign bus.win_col_o    = wcol_q;
    assign bus.frame_done_o = done_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed checks of window generation on a 4x5 frame
module tb_window_gen_3x3;
    localparam int R = 4;
    localparam int C = 5;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_gen_3x3_if #(.DATA_W(W)) bus ();
    window_gen_3x3 #(.MAX_ROW(R), .MAX_COL(C), .DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int er, ec, base, wins, dones;
    bit gaps;
    logic [9*W-1:0] last_win;

    task automatic cmp(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] pv(input int r, input int c);
        return 8'(base + 10 * r + c);
    endfunction

    task automatic step(input logic en, input logic clr, input logic rs, input logic [7:0] d);
        rst = rs;
        bus.data_en_i = en;
        bus.clear_i = clr;
        bus.data_i = d;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.data_en_i = 1'b0;
        bus.clear_i = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'($urandom));
        cmp("gap_en", bus.win_en_o, 1'b0);
        cmp("gap_done", bus.frame_done_o, 1'b0);
        cmp("gap_hold", bus.win_o, last_win);
    endtask

    task automatic pix();
        logic ew, ed;
        logic [71:0] ex;
        ex = '0;
        step(1'b1, 1'b0, 1'b0, pv(er, ec));
        ew = er >= 2 && ec >= 2;
        ed = er == R - 1 && ec == C - 1;
        cmp("win_en", bus.win_en_o, ew);
        cmp("frame_done", bus.frame_done_o, ed);
        if (ew) begin
            for (int y = 0; y < 3; y++)
                for (int x = 0; x < 3; x++)
                    ex[(3*y+x)*W +: W] = pv(er - 2 + y, ec - 2 + x);
            cmp("win", bus.win_o, ex);
            cmp("row", bus.win_row_o, 72'(er - 1));
            cmp("col", bus.win_col_o, 72'(ec - 1));
            if (er == 2 && ec == 2 && base == 0) cmp("first_win_f0", bus.win_o, 72'h161514_0C0B0A_020100);
            if (er == 2 && ec == 2 && base == 100) cmp("first_win_f1", bus.win_o, 72'h7A7978_706F6E_666564);
            last_win = ex;
            wins++;
            if (ed) dones++;
        end else cmp("win_hold", bus.win_o, last_win);
        if (ec == C - 1) begin
            ec = 0;
            er = (er == R - 1) ? 0 : er + 1;
        end else ec++;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ((i % 2 == 0) ? 1 : $urandom_range(0, 5)) idle();
            pix();
        end
    endtask

    initial begin
        bus.data_i = '0;
        bus.data_en_i = 1'b0;
        bus.clear_i = 1'b0;
        rst = 1'b1;
        er = 0; ec = 0; base = 0; wins = 0; dones = 0; gaps = 1'b0; last_win = '0;
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h5A);
        cmp("rst_win", bus.win_o, 72'h0);
        cmp("rst_en", bus.win_en_o, 1'b0);
        cmp("rst_row", bus.win_row_o, 72'h0);
        cmp("rst_col", bus.win_col_o, 72'h0);
        cmp("rst_done", bus.frame_done_o, 1'b0);

        // 1: continuous frame
        stream(R * C);
        cmp("s1_wins", wins, 6);
        cmp("s1_dones", dones, 1);

        // 2: same frame with gaps
        wins = 0; dones = 0; gaps = 1'b1;
        stream(R * C);
        idle();
        cmp("s2_wins", wins, 6);
        cmp("s2_dones", dones, 1);

        // 3: two frames back-to-back
        wins = 0; dones = 0; gaps = 1'b0;
        stream(R * C);
        base = 100;
        stream(R * C);
        base = 0;
        cmp("s3_wins", wins, 12);
        cmp("s3_dones", dones, 2);

        // 4: clear at pixel (2,1) with data present, then a fresh frame
        stream(2 * C + 1);
        step(1'b1, 1'b1, 1'b0, 8'hEE);
        cmp("clr_en", bus.win_en_o, 1'b0);
        cmp("clr_done", bus.frame_done_o, 1'b0);
        er = 0; ec = 0; wins = 0; dones = 0;
        stream(R * C);
        cmp("s4_wins", wins, 6);
        cmp("s4_dones", dones, 1);

        // 5: reset at pixel (3,2), then a fresh frame
        stream(3 * C + 2);
        step(1'b1, 1'b0, 1'b1, pv(3, 2));
        cmp("mrst_win", bus.win_o, 72'h0);
        cmp("mrst_en", bus.win_en_o, 1'b0);
        cmp("mrst_row", bus.win_row_o, 72'h0);
        cmp("mrst_col", bus.win_col_o, 72'h0);
        cmp("mrst_done", bus.frame_done_o, 1'b0);
        last_win = '0; er = 0; ec = 0; wins = 0; dones = 0;
        stream(R * C);
        idle();
        cmp("s5_wins", wins, 6);
        cmp("s5_dones", dones, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
